// File: rtl/eth_sniffer_pkg.sv
// Shared constants, state encoding and slot address table for the result-slot logic.
package eth_sniffer_pkg;

   localparam int unsigned NUM_SLOTS   = 5;
   localparam int unsigned SLOT_STRIDE = 1550;
   localparam int unsigned MAX_WORDS   = 386;

   localparam logic [2:0] LAST_SLOT   = 3'(NUM_SLOTS - 1);
   localparam logic [8:0] MAX_WORDS_W = 9'(MAX_WORDS);

   typedef enum logic [1:0] {
      StIdle,
      StWrite,
      StCommit,
      StDrop
   } state_e;

   // Byte address of the header word of slot idx (idx * SLOT_STRIDE).
   function automatic logic [31:0] slot_base(input logic [2:0] idx);
      logic [31:0] base;
      case (idx)
         3'd0:    base = 32'h0000_0000;
         3'd1:    base = 32'h0000_060E;
         3'd2:    base = 32'h0000_0C1C;
         3'd3:    base = 32'h0000_122A;
         3'd4:    base = 32'h0000_1838;
         default: base = 32'h0000_0000;
      endcase
      return base;
   endfunction

   // Ring increment over the slot indices.
   function automatic logic [2:0] next_slot(input logic [2:0] idx);
      return (idx == LAST_SLOT) ? 3'd0 : idx + 3'd1;
   endfunction

endpackage

// File: rtl/result_slot_tracker.sv
// Ring pointers and occupancy for the committed result slots.
module result_slot_tracker
   import eth_sniffer_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       alloc_i,
   input  logic       release_i,
   output logic [2:0] wr_ptr_o,
   output logic [2:0] rd_ptr_o,
   output logic       slot_avail_o
);

   logic [2:0] wr_ptr_q, wr_ptr_d;
   logic [2:0] rd_ptr_q, rd_ptr_d;
   logic [2:0] occ_q, occ_d;
   logic       do_release;

   // Release only means something when a slot is actually held.
   always_comb begin
      do_release = release_i && (occ_q != 3'd0);
      wr_ptr_d   = alloc_i ? next_slot(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d   = do_release ? next_slot(rd_ptr_q) : rd_ptr_q;
      occ_d      = occ_q;
      case ({alloc_i, do_release})
         2'b10:   occ_d = occ_q + 3'd1;
         2'b01:   occ_d = occ_q - 3'd1;
         default: occ_d = occ_q;
      endcase
   end

   // Pointer and occupancy registers, synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= 3'd0;
         rd_ptr_q <= 3'd0;
         occ_q    <= 3'd0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         occ_q    <= occ_d;
      end
   end

   assign wr_ptr_o     = wr_ptr_q;
   assign rd_ptr_o     = rd_ptr_q;
   assign slot_avail_o = (occ_q < 3'(NUM_SLOTS));

endmodule

// File: rtl/result_slot_controller.sv
// Streams packet payload into ring slots of an output buffer, then writes a length header.
module result_slot_controller
   import eth_sniffer_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        pkt_start,
   input  logic        pkt_valid,
   input  logic [31:0] pkt_data,
   input  logic        pkt_end,
   input  logic        pkt_abort,
   input  logic        host_release,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        slot_avail,
   output logic        done_valid,
   output logic [2:0]  done_slot,
   output logic [15:0] done_len,
   output logic [15:0] drop_cnt
);

   state_e      state_q, state_d;
   logic [2:0]  slot_q, slot_d;
   logic [8:0]  count_q, count_d;
   logic [15:0] drop_cnt_q, drop_cnt_d;
   logic        mem_we_q, mem_we_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic        done_valid_q, done_valid_d;
   logic [2:0]  done_slot_q, done_slot_d;
   logic [15:0] done_len_q, done_len_d;
   logic        drop_inc;
   logic        alloc;
   logic [2:0]  wr_ptr;
   logic [2:0]  rd_ptr;
   logic [15:0] len_bytes;

   result_slot_tracker u_tracker (
      .clk_i        (clk),
      .rst_i        (rst),
      .alloc_i      (alloc),
      .release_i    (host_release),
      .wr_ptr_o     (wr_ptr),
      .rd_ptr_o     (rd_ptr),
      .slot_avail_o (slot_avail)
   );

   assign len_bytes = {5'b0, count_q, 2'b00};

   // Next state and next registered outputs; strobes default low every cycle.
   always_comb begin
      state_d      = state_q;
      slot_d       = slot_q;
      count_d      = count_q;
      drop_inc     = 1'b0;
      alloc        = 1'b0;
      mem_we_d     = 1'b0;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      done_valid_d = 1'b0;
      done_slot_d  = done_slot_q;
      done_len_d   = done_len_q;
      unique case (state_q)
         StIdle: begin
            if (pkt_start) begin
               if (slot_avail) begin
                  state_d = StWrite;
                  count_d = 9'd0;
                  slot_d  = wr_ptr;
               end else begin
                  state_d  = StDrop;
                  drop_inc = 1'b1;
               end
            end
         end
         StWrite: begin
            if (pkt_abort) begin
               state_d = StIdle;
            end else if (pkt_valid && (count_q == MAX_WORDS_W)) begin
               // Oversized packet: if it also ends here there is no tail to swallow.
               drop_inc = 1'b1;
               state_d  = pkt_end ? StIdle : StDrop;
            end else begin
               if (pkt_valid) begin
                  mem_we_d    = 1'b1;
                  mem_addr_d  = slot_base(slot_q) + 32'd4 + {21'b0, count_q, 2'b00};
                  mem_wdata_d = pkt_data;
                  count_d     = count_q + 9'd1;
               end
               if (pkt_end) begin
                  state_d = StCommit;
               end
            end
         end
         StCommit: begin
            mem_we_d     = 1'b1;
            mem_addr_d   = slot_base(slot_q);
            mem_wdata_d  = {16'b0, len_bytes};
            done_valid_d = 1'b1;
            done_slot_d  = slot_q;
            done_len_d   = len_bytes;
            alloc        = 1'b1;
            state_d      = StIdle;
         end
         StDrop: begin
            if (pkt_end || pkt_abort) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
      drop_cnt_d = (drop_inc && (drop_cnt_q != 16'hFFFF)) ? drop_cnt_q + 16'd1 : drop_cnt_q;
   end

   // State and output registers, synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         slot_q       <= 3'd0;
         count_q      <= 9'd0;
         drop_cnt_q   <= 16'd0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= 32'd0;
         mem_wdata_q  <= 32'd0;
         done_valid_q <= 1'b0;
         done_slot_q  <= 3'd0;
         done_len_q   <= 16'd0;
      end else begin
         state_q      <= state_d;
         slot_q       <= slot_d;
         count_q      <= count_d;
         drop_cnt_q   <= drop_cnt_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         done_valid_q <= done_valid_d;
         done_slot_q  <= done_slot_d;
         done_len_q   <= done_len_d;
      end
   end

   assign mem_we     = mem_we_q;
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;
   assign done_valid = done_valid_q;
   assign done_slot  = done_slot_q;
   assign done_len   = done_len_q;
   assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_result_slot_controller.sv
// Scoreboard bench: stimulus pushes expected writes/commits, a negedge monitor pops and compares.
module tb_result_slot_controller;

   logic        clk;
   logic        rst;
   logic        pkt_start;
   logic        pkt_valid;
   logic [31:0] pkt_data;
   logic        pkt_end;
   logic        pkt_abort;
   logic        host_release;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        slot_avail;
   logic        done_valid;
   logic [2:0]  done_slot;
   logic [15:0] done_len;
   logic [15:0] drop_cnt;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   typedef struct {
      logic [2:0]  slot;
      logic [15:0] len;
   } done_t;

   wr_t   exp_wr[$];
   done_t exp_done[$];
   int    checks;
   int    errors;

   result_slot_controller dut (
      .clk          (clk),
      .rst          (rst),
      .pkt_start    (pkt_start),
      .pkt_valid    (pkt_valid),
      .pkt_data     (pkt_data),
      .pkt_end      (pkt_end),
      .pkt_abort    (pkt_abort),
      .host_release (host_release),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .slot_avail   (slot_avail),
      .done_valid   (done_valid),
      .done_slot    (done_slot),
      .done_len     (done_len),
      .drop_cnt     (drop_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] base_of(input int k);
      return 32'(k * 1550);
   endfunction

   // Monitor: every write strobe and commit pulse must match the oldest expectation.
   always @(negedge clk) begin
      if (mem_we === 1'b1) begin
         if (exp_wr.size() == 0) begin
            check("unexpected_write_addr", mem_addr, 32'hFFFF_FFFF);
         end else begin
            wr_t e;
            e = exp_wr.pop_front();
            check("write_addr", mem_addr, e.addr);
            check("write_data", mem_wdata, e.data);
         end
      end
      if (done_valid === 1'b1) begin
         if (exp_done.size() == 0) begin
            check("unexpected_done_slot", 32'(done_slot), 32'hFFFF_FFFF);
         end else begin
            done_t d;
            d = exp_done.pop_front();
            check("done_slot", 32'(done_slot), 32'(d.slot));
            check("done_len", 32'(done_len), 32'(d.len));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
      check({tag, "_mem_addr"}, mem_addr, 32'd0);
      check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
      check({tag, "_done_valid"}, 32'(done_valid), 32'd0);
      check({tag, "_done_slot"}, 32'(done_slot), 32'd0);
      check({tag, "_done_len"}, 32'(done_len), 32'd0);
      check({tag, "_drop_cnt"}, 32'(drop_cnt), 32'd0);
      check({tag, "_slot_avail"}, 32'(slot_avail), 32'd1);
   endtask

   task automatic do_reset(input string tag);
      rst = 1'b1;
      tick();
      check_reset_outputs(tag);
      tick();
      rst = 1'b0;
      tick();
   endtask

   // slot < 0: packet expected to be dropped at start. n > 386: oversize drop.
   task automatic send_pkt(input int n, input logic [31:0] seed, input int slot,
                           input bit end_sep, input bit rel_commit);
      int nw;
      nw = (n > 386) ? 386 : n;
      if (slot >= 0) begin
         for (int i = 0; i < nw; i++) begin
            exp_wr.push_back(wr_t'{base_of(slot) + 32'(4 + 4 * i), seed + 32'(i)});
         end
         if (n <= 386) begin
            exp_wr.push_back(wr_t'{base_of(slot), 32'(4 * n)});
            exp_done.push_back(done_t'{3'(slot), 16'(4 * n)});
         end
      end
      pkt_start = 1'b1;
      tick();
      pkt_start = 1'b0;
      for (int i = 0; i < n; i++) begin
         pkt_valid = 1'b1;
         pkt_data  = seed + 32'(i);
         pkt_end   = (!end_sep && (i == n - 1));
         tick();
      end
      pkt_valid = 1'b0;
      pkt_end   = 1'b0;
      if (end_sep || n == 0) begin
         pkt_end = 1'b1;
         tick();
         pkt_end = 1'b0;
      end
      host_release = rel_commit;
      tick();
      host_release = 1'b0;
      tick();
      tick();
   endtask

   initial begin
      checks       = 0;
      errors       = 0;
      rst          = 1'b1;
      pkt_start    = 1'b0;
      pkt_valid    = 1'b0;
      pkt_data     = 32'd0;
      pkt_end      = 1'b0;
      pkt_abort    = 1'b0;
      host_release = 1'b0;
      tick();
      do_reset("rst0");

      // Single three-word packet into slot 0.
      send_pkt(3, 32'hA, 0, 1'b0, 1'b0);
      check("single_drop_cnt", 32'(drop_cnt), 32'd0);

      // Fill all five slots, sixth packet dropped.
      do_reset("rst1");
      send_pkt(1, 32'h1000, 0, 1'b0, 1'b0);
      send_pkt(2, 32'h2000, 1, 1'b1, 1'b0);
      send_pkt(0, 32'h0,    2, 1'b1, 1'b0);
      check("avail_occ3", 32'(slot_avail), 32'd1);
      send_pkt(4, 32'h4000, 3, 1'b0, 1'b0);
      send_pkt(2, 32'h5000, 4, 1'b1, 1'b0);
      check("full_avail", 32'(slot_avail), 32'd0);
      check("full_drop_cnt", 32'(drop_cnt), 32'd0);
      send_pkt(2, 32'h6000, -1, 1'b1, 1'b0);
      check("sixth_drop_cnt", 32'(drop_cnt), 32'd1);

      // One release frees slot 0; next packet wraps into it.
      host_release = 1'b1;
      tick();
      host_release = 1'b0;
      check("release_avail", 32'(slot_avail), 32'd1);
      send_pkt(1, 32'h7000, 0, 1'b0, 1'b0);
      check("refill_avail", 32'(slot_avail), 32'd0);
      check("refill_drop_cnt", 32'(drop_cnt), 32'd1);

      // Oversize packet: 386 words land, 387th forces a drop, slot kept.
      do_reset("rst2");
      send_pkt(387, 32'h8000_0000, 0, 1'b1, 1'b0);
      check("oversize_drop_cnt", 32'(drop_cnt), 32'd1);
      send_pkt(1, 32'h9000, 0, 1'b0, 1'b0);

      // Abort after two words, abort beats a same-cycle valid/end; slot 1 reused.
      exp_wr.push_back(wr_t'{base_of(1) + 32'd4, 32'hAB00});
      exp_wr.push_back(wr_t'{base_of(1) + 32'd8, 32'hAB01});
      pkt_start = 1'b1;
      tick();
      pkt_start = 1'b0;
      pkt_valid = 1'b1;
      pkt_data  = 32'hAB00;
      tick();
      pkt_data  = 32'hAB01;
      tick();
      pkt_data  = 32'hAB02;
      pkt_end   = 1'b1;
      pkt_abort = 1'b1;
      tick();
      pkt_valid = 1'b0;
      pkt_end   = 1'b0;
      pkt_abort = 1'b0;
      tick();
      tick();
      check("abort_drop_cnt", 32'(drop_cnt), 32'd1);
      send_pkt(1, 32'hCD00, 1, 1'b0, 1'b0);

      // Occupancy 2 -> 3, then commit with simultaneous release keeps it at 3.
      send_pkt(2, 32'hE000, 2, 1'b0, 1'b0);
      send_pkt(1, 32'hE100, 3, 1'b0, 1'b1);
      send_pkt(1, 32'hE200, 4, 1'b0, 1'b0);
      check("occ4_avail", 32'(slot_avail), 32'd1);
      send_pkt(1, 32'hE300, 0, 1'b0, 1'b0);
      check("occ5_avail", 32'(slot_avail), 32'd0);

      // Reset in the middle of a packet into a fresh slot.
      do_reset("rst3");
      exp_wr.push_back(wr_t'{base_of(0) + 32'd4, 32'hF000});
      exp_wr.push_back(wr_t'{base_of(0) + 32'd8, 32'hF001});
      pkt_start = 1'b1;
      tick();
      pkt_start = 1'b0;
      pkt_valid = 1'b1;
      pkt_data  = 32'hF000;
      tick();
      pkt_data  = 32'hF001;
      tick();
      pkt_data  = 32'hF002;
      pkt_end   = 1'b1;
      rst       = 1'b1;
      tick();
      check_reset_outputs("midrst");
      rst       = 1'b0;
      pkt_valid = 1'b0;
      pkt_end   = 1'b0;
      for (int i = 0; i < 4; i++) tick();

      check("pending_writes", 32'(exp_wr.size()), 32'd0);
      check("pending_dones", 32'(exp_done.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
